// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus ports: field widths, burst field layout
// and the master port state encoding.
package bus_pkg;

  localparam int ADDR_W          = 12;
  localparam int DATA_W          = 8;
  localparam int BLEN_W          = 12;
  localparam int BURST_W         = BLEN_W + 1;
  localparam int BURST_FLAG_BIT  = 0;
  localparam int HDR_BITS        = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_SPLIT
  } mp_state_t;

  // Burst field: bit0 flags a multi-beat transfer, upper bits carry beats-1.
  function automatic logic [BURST_W-1:0] make_burst(input logic [BLEN_W-1:0] blen);
    return {blen, (blen != '0)};
  endfunction

endpackage

// File: rtl/master_bit_shifter.sv
// LSB-first shift register shared by the tx (PISO) and rx (SIPO) paths, with a
// bit counter that flags the shift completing a word.
module master_bit_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         serial_in,
  output logic [W-1:0] par_out,
  output logic         done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt_q  <= '0;
    end else if (shift) begin
      data_q <= {serial_in, data_q[W-1:1]};
      cnt_q  <= done ? '0 : cnt_q + CW'(1);
    end
  end

  assign par_out = data_q;
  assign done    = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/master_port.sv
// Master-side serial bus port: arbitrates for the bus, serialises header and
// write data, deserialises read data and returns one response per beat.
module master_port import bus_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BLEN_W-1:0] req_blen,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_error,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              read_en,
  output logic              write_en,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              tx_address,
  output logic              tx_burst,
  output logic              tx_data,
  input  logic              slave_valid,
  output logic              master_ready,
  input  logic              rx_data,
  input  logic              split_en
);

  localparam int HDR_CW = $clog2(HDR_BITS);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  mp_state_t           state;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [BLEN_W-1:0]   lat_blen;
  logic [BLEN_W-1:0]   beat_cnt;
  logic [HDR_BITS-1:0] addr_sr;
  logic [HDR_BITS-1:0] burst_sr;
  logic [HDR_CW-1:0]   hdr_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                beat_loaded;

  logic                sh_clear;
  logic                sh_load;
  logic                sh_shift;
  logic                sh_done;
  logic [DATA_W-1:0]   sh_par;
  logic [DATA_W-1:0]   rx_word;

  logic tx_hs;
  logic rx_hs;
  logic grant_lost;
  logic timed_out;
  logic beat_end;
  logic txn_end;
  logic abort;

  assign tx_hs = master_valid & slave_ready;
  assign rx_hs = slave_valid & master_ready;

  assign tx_address = addr_sr[0];
  assign tx_burst   = burst_sr[0];
  assign tx_data    = write_en & sh_par[0];
  assign rx_word    = {rx_data, sh_par[DATA_W-1:1]};

  // A split in RWAIT legitimately gives the bus back, so it is not a grant loss.
  assign grant_lost = !bus_grant &&
                      ((state inside {ST_ADDR, ST_WDATA, ST_RDATA}) ||
                       (state == ST_RWAIT && !split_en));
  assign timed_out  = (state == ST_RWAIT) && bus_grant && !split_en && !rx_hs &&
                      (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign abort      = grant_lost || timed_out;

  assign sh_clear = (state == ST_IDLE);
  assign sh_load  = (state == ST_WDATA) && !beat_loaded && wr_valid && bus_grant;
  assign sh_shift = ((state == ST_WDATA) && beat_loaded && tx_hs && bus_grant) ||
                    ((state == ST_RWAIT) && rx_hs && !split_en && bus_grant) ||
                    ((state == ST_RDATA) && rx_hs && bus_grant);
  assign beat_end = sh_shift && sh_done;
  assign txn_end  = beat_end && (beat_cnt == lat_blen);

  master_bit_shifter #(.W(DATA_W)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear     (sh_clear),
    .load      (sh_load),
    .load_data (wr_data),
    .shift     (sh_shift),
    .serial_in (lat_write ? 1'b0 : rx_data),
    .par_out   (sh_par),
    .done      (sh_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b0;
      wr_ready     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_last     <= 1'b0;
      rsp_error    <= 1'b0;
      bus_req      <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      master_valid <= 1'b0;
      master_ready <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_blen     <= '0;
      beat_cnt     <= '0;
      hdr_cnt      <= '0;
      tmo_cnt      <= '0;
      beat_loaded  <= 1'b0;
      addr_sr      <= '0;
      burst_sr     <= '0;
    end else begin
      wr_ready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
      rsp_error <= 1'b0;
      // Final beat or error: respond and release the bus in the same cycle.
      if (abort || txn_end) begin
        state        <= ST_IDLE;
        req_ready    <= 1'b1;
        bus_req      <= 1'b0;
        read_en      <= 1'b0;
        write_en     <= 1'b0;
        master_valid <= 1'b0;
        master_ready <= 1'b0;
        beat_loaded  <= 1'b0;
        addr_sr      <= '0;
        burst_sr     <= '0;
        rsp_valid    <= 1'b1;
        rsp_last     <= 1'b1;
        rsp_error    <= abort;
        if (!abort && !lat_write) rsp_rdata <= rx_word;
      end else begin
        case (state)
          ST_IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              req_ready <= 1'b0;
              lat_write <= req_write;
              lat_addr  <= req_addr;
              lat_blen  <= req_blen;
              bus_req   <= 1'b1;
              state     <= ST_ARB;
            end
          end
          ST_ARB: begin
            if (bus_grant) begin
              state        <= ST_ADDR;
              read_en      <= !lat_write;
              write_en     <= lat_write;
              master_valid <= 1'b1;
              addr_sr      <= HDR_BITS'(lat_addr);
              burst_sr     <= HDR_BITS'(make_burst(lat_blen));
              hdr_cnt      <= '0;
            end
          end
          ST_ADDR: begin
            if (tx_hs) begin
              addr_sr  <= addr_sr >> 1;
              burst_sr <= burst_sr >> 1;
              hdr_cnt  <= hdr_cnt + HDR_CW'(1);
              if (hdr_cnt == HDR_CW'(HDR_BITS - 1)) begin
                master_valid <= 1'b0;
                beat_cnt     <= '0;
                beat_loaded  <= 1'b0;
                if (lat_write) begin
                  state <= ST_WDATA;
                end else begin
                  state        <= ST_RWAIT;
                  master_ready <= 1'b1;
                  tmo_cnt      <= '0;
                end
              end
            end
          end
          ST_WDATA: begin
            if (!beat_loaded) begin
              if (wr_valid) begin
                beat_loaded  <= 1'b1;
                master_valid <= 1'b1;
                wr_ready     <= 1'b1;
              end
            end else if (beat_end) begin
              beat_loaded  <= 1'b0;
              master_valid <= 1'b0;
              rsp_valid    <= 1'b1;
              beat_cnt     <= beat_cnt + BLEN_W'(1);
            end
          end
          ST_RWAIT: begin
            if (split_en) begin
              state        <= ST_SPLIT;
              bus_req      <= 1'b0;
              master_ready <= 1'b0;
            end else if (rx_hs) begin
              state <= ST_RDATA;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          ST_RDATA: begin
            if (beat_end) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rx_word;
              beat_cnt  <= beat_cnt + BLEN_W'(1);
            end
          end
          ST_SPLIT: begin
            bus_req <= !split_en;
            if (!split_en && bus_req && bus_grant) begin
              state        <= ST_RWAIT;
              master_ready <= 1'b1;
              tmo_cnt      <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: a queue of expected responses is filled as
// requests are issued and drained by an independent response monitor.
module tb_master_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr, req_blen;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data, rsp_rdata;
  logic        rsp_valid, rsp_last, rsp_error;
  logic        bus_req, bus_grant, read_en, write_en;
  logic        master_valid, slave_ready, tx_address, tx_burst, tx_data;
  logic        slave_valid, master_ready, rx_data, split_en;

  typedef struct packed {
    logic [7:0] rdata;
    logic       last;
    logic       err;
  } rsp_t;

  typedef struct packed {
    logic addr;
    logic burst;
    logic data;
  } txbit_t;

  rsp_t   exp_q[$];
  txbit_t tx_log[$];
  int     checks = 0;
  int     errors = 0;
  logic   ready_toggle = 1'b0;

  master_port #(.TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_blen(req_blen),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_error(rsp_error),
    .bus_req(bus_req), .bus_grant(bus_grant), .read_en(read_en), .write_en(write_en),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .tx_address(tx_address), .tx_burst(tx_burst), .tx_data(tx_data),
    .slave_valid(slave_valid), .master_ready(master_ready), .rx_data(rx_data),
    .split_en(split_en)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({req_ready, wr_ready, rsp_valid, rsp_rdata, rsp_last, rsp_error, bus_req,
                read_en, write_en, master_valid, master_ready, tx_address, tx_burst, tx_data});
  endfunction

  function automatic logic sig(input int id);
    case (id)
      0:       return req_ready;
      1:       return wr_ready;
      default: return master_ready;
    endcase
  endfunction

  // Simple arbiter and slave-ready driver, updated just after every rising edge.
  initial begin
    bus_grant   = 1'b0;
    slave_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus_grant   = bus_req;
      slave_ready = ready_toggle ? !slave_ready : 1'b1;
    end
  end

  // Response monitor: every response beat must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rdata=0x%0h last=%0b err=%0b required none",
                 rsp_rdata, rsp_last, rsp_error);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check_output("rsp", 32'({rsp_rdata, rsp_last, rsp_error}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && master_valid && slave_ready)
      tx_log.push_back({tx_address, tx_burst, tx_data});
  end

  task automatic wait_high(input string name, input int id, input int limit);
    int n = 0;
    while (!sig(id) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!sig(id)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_%s: got timeout after %0d cycles required high", name, limit);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [11:0] addr, input logic [11:0] blen);
    wait_high("req_ready", 0, 50);
    tx_log.delete();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_blen  = blen;
    cycles(1);
    req_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      slave_valid = 1'b1;
      rx_data     = d[i];
      cycles(1);
    end
    slave_valid = 1'b0;
    rx_data     = 1'b0;
  endtask

  task automatic check_tx(input string name, input logic [12:0] ea, input logic [12:0] eb,
                          input logic [7:0] ed, input int nd);
    logic [12:0] a = '0;
    logic [12:0] b = '0;
    logic [7:0]  d = '0;
    check_output({name, "_nbits"}, 32'(tx_log.size()), 32'(13 + nd));
    for (int i = 0; i < 13 && i < tx_log.size(); i++) begin
      a[i] = tx_log[i].addr;
      b[i] = tx_log[i].burst;
    end
    for (int i = 0; i < nd && 13 + i < tx_log.size(); i++) d[i] = tx_log[13 + i].data;
    check_output({name, "_addr"}, 32'(a), 32'(ea));
    check_output({name, "_burst"}, 32'(b), 32'(eb));
    check_output({name, "_data"}, 32'(d), 32'(ed));
  endtask

  initial begin
    int   n;
    logic saw_req, saw_ready;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_blen = '0;
    wr_valid = 1'b0; wr_data = '0;
    slave_valid = 1'b0; rx_data = 1'b0; split_en = 1'b0;
    cycles(3);
    check_output("reset_outputs", all_outputs(), 32'h0);
    reset = 1'b0;
    cycles(1);
    check_output("req_ready_after_reset", 32'(req_ready), 32'h1);

    // 1: single write
    wr_valid = 1'b1; wr_data = 8'h3C;
    exp_q.push_back('{8'h00, 1'b1, 1'b0});
    apply_stimulus(1'b1, 12'hA5C, 12'd0);
    wait_high("wr_ready", 1, 100);
    wr_valid = 1'b0;
    wait_high("req_ready", 0, 100);
    check_tx("wr1", 13'h0A5C, 13'h0000, 8'h3C, 8);

    // 2: single read with 3 idle cycles before data
    exp_q.push_back('{8'hC3, 1'b1, 1'b0});
    apply_stimulus(1'b0, 12'h010, 12'd0);
    wait_high("master_ready", 2, 100);
    cycles(3);
    send_byte(8'hC3);
    wait_high("req_ready", 0, 50);
    check_tx("rd1", 13'h0010, 13'h0000, 8'h00, 0);

    // 3: burst read of four beats
    exp_q.push_back('{8'h11, 1'b0, 1'b0});
    exp_q.push_back('{8'h22, 1'b0, 1'b0});
    exp_q.push_back('{8'h33, 1'b0, 1'b0});
    exp_q.push_back('{8'h44, 1'b1, 1'b0});
    apply_stimulus(1'b0, 12'h100, 12'd3);
    wait_high("master_ready", 2, 100);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_high("req_ready", 0, 50);
    check_tx("rd4", 13'h0100, 13'h0007, 8'h00, 0);

    // 4: split with a coincident bit that must be discarded
    exp_q.push_back('{8'h5A, 1'b1, 1'b0});
    apply_stimulus(1'b0, 12'h3F0, 12'd0);
    wait_high("master_ready", 2, 100);
    split_en = 1'b1; slave_valid = 1'b1; rx_data = 1'b1;
    cycles(1);
    slave_valid = 1'b0; rx_data = 1'b0;
    saw_req = 1'b0; saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      saw_req   = saw_req | bus_req;
      saw_ready = saw_ready | master_ready;
      cycles(1);
    end
    check_output("split_bus_req_low", 32'(saw_req), 32'h0);
    check_output("split_master_ready_low", 32'(saw_ready), 32'h0);
    split_en = 1'b0;
    wait_high("master_ready", 2, 50);
    send_byte(8'h5A);
    wait_high("req_ready", 0, 50);

    // 5: read timeout
    exp_q.push_back('{8'h00, 1'b1, 1'b1});
    apply_stimulus(1'b0, 12'h7FF, 12'd0);
    wait_high("master_ready", 2, 100);
    n = 0;
    while (!rsp_error && n < 400) begin
      cycles(1);
      n++;
    end
    check_output("timeout_cycles", 32'(n), 32'd255);
    check_output("idle_after_timeout", 32'(req_ready), 32'h1);

    // 6a: slave_ready backpressure during the header and data
    ready_toggle = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h96;
    exp_q.push_back('{8'h00, 1'b1, 1'b0});
    apply_stimulus(1'b1, 12'h5A3, 12'd0);
    wait_high("wr_ready", 1, 200);
    wr_valid = 1'b0;
    wait_high("req_ready", 0, 100);
    check_tx("wr_bp", 13'h05A3, 13'h0000, 8'h96, 8);
    ready_toggle = 1'b0;

    // 6b: reset while write data is shifting out
    wr_valid = 1'b1; wr_data = 8'hFF;
    apply_stimulus(1'b1, 12'h0FF, 12'd0);
    wait_high("wr_ready", 1, 100);
    wr_valid = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    check_output("reset_mid_wdata", all_outputs(), 32'h0);
    reset = 1'b0;
    cycles(1);
    check_output("req_ready_after_abort", 32'(req_ready), 32'h1);

    cycles(5);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
